switch_sweep_ctrl: RTL
======================

Name: switch_sweep_ctrl

Overview:
Sequencer that exercises the 3-input combinational SWITCH block in hardware. On a start pulse it drives x1/x2/x3 through all 8 input combinations, holds each for DWELL cycles, samples y, and builds an 8-entry truth table. The table is compared against a caller-supplied expected table, and the block reports pass/fail plus a per-entry mismatch mask. It sits between a host or self-test controller and one SWITCH instance.

Parameters:
DWELL, 20, clock cycles each input combination is held before y is sampled (legal range 1..65535).
CW, derived, dwell counter width = max(1, clog2(DWELL)); not overridden by users.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
start  in  1  request a sweep; accepted only in IDLE
abort  in  1  cancel a sweep in progress
expected  in  8  expected truth table; bit i = expected y for input index i
y_in  in  1  y output of the SWITCH under control
x1  out  1  SWITCH input, MSB of index
x2  out  1  SWITCH input, middle bit of index
x3  out  1  SWITCH input, LSB of index
busy  out  1  high while sweeping
done  out  1  one-cycle pulse at sweep completion
pass  out  1  table == expected of the last completed sweep
table  out  8  captured truth table, bit i = y sampled at index i
mismatch  out  8  table XOR expected of the last completed sweep
idx  out  3  current input index

Behaviour:
- Reset (rst=1 at an edge, dominates all other inputs): state=IDLE, idx=0, {x1,x2,x3}=000, busy=0, done=0, pass=0, table=0, mismatch=0, dwell counter=0.
- {x1,x2,x3} = idx directly from the idx register, with no extra pipeline stage. In IDLE they are forced to 000.
- States are IDLE, SWEEP and DONE.
- IDLE: if start=1 and abort=0 at an edge, then exp_q<=expected, table<=0, mismatch<=0, pass<=0, idx<=0, cnt<=0, busy<=1, go to SWEEP. If start=1 and abort=1, stay in IDLE.
- SWEEP:
  - If abort=1: go to IDLE, busy<=0, idx<=0, no done pulse, pass stays 0. The partial table is retained; mismatch stays 0.
  - Else if cnt==DWELL-1: table[idx]<=y_in and cnt<=0. If idx==7, go to DONE; otherwise idx<=idx+1.
  - Else cnt<=cnt+1.
  - start is ignored in SWEEP.
- DONE (exactly one cycle):
  - done=1, busy=0, pass<=(table==exp_q), mismatch<=table^exp_q.
  - The compare uses the fully updated table, including bit 7 written on the DONE-entry edge.
  - Next edge returns to IDLE. start during DONE is ignored; abort has no effect.
- Latency: the final sample occurs on the 8*DWELL-th edge after the accepting edge. done is high in the following cycle, and pass/mismatch are valid from the edge ending DONE.
- pass, mismatch and table hold until the next accepted start or reset.
- y_in is sampled only at the end of the dwell; intermediate glitches are ignored.
- DWELL=1: each index is driven for exactly one cycle and sampled at the next edge.
- expected changes after start have no effect (latched in exp_q).

Test Plan:
- Reset: assert rst for 2 cycles mid-random stimulus -> x=000, busy=0, done=0, pass=0, table=0x00, mismatch=0x00.
- Golden sweep, DWELL=4, SWITCH modelled as y=x1^x2^x3, expected=0x96, single start pulse:
  - x steps 000,001,...,111, each held 4 cycles.
  - done pulses once, 32 edges after accept, then one cycle.
  - Result: table=0x96, pass=1, mismatch=0x00, busy low after done.
- Fault detect: same setup with expected=0x97 -> pass=0, mismatch=0x01, table=0x96.
- Abort at idx=3, mid-dwell -> next edge busy=0, x=000, no done pulse, pass=0, table bits 2:0 hold the sampled values and bits 7:3=0.
- Start handling:
  - start held high during SWEEP and during the DONE cycle -> no restart; exactly one done.
  - start+abort together in IDLE -> stays IDLE, busy=0.
- Sync reset mid-sweep at idx=5 -> all outputs at reset values after that edge; sweep does not resume without a new start. A following DWELL=1 build sweep completes with done 8 edges after accept and table=0x96.

Source files
------------

// File: rtl/switch_sweep_ctrl.sv
// Sweeps a 3-input SWITCH through all 8 input combinations, captures its truth table
// and checks it against a latched expected table. 'table' is a reserved word, so that port is tbl.
module switch_sweep_ctrl #(
   parameter int unsigned DWELL = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       y_in,
   output logic       x1,
   output logic       x2,
   output logic       x3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] tbl,
   output logic [7:0] mismatch,
   output logic [2:0] idx
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    exp_q;

   assign {x1, x2, x3} = (state == IDLE) ? 3'b000 : idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         cnt      <= '0;
         exp_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         tbl      <= '0;
         mismatch <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  exp_q    <= expected;
                  tbl      <= '0;
                  mismatch <= '0;
                  pass     <= 1'b0;
                  idx      <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= SWEEP;
               end
            end
            SWEEP: begin
               if (abort) begin
                  // partial table is kept for inspection; no done pulse
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  tbl[idx] <= y_in;
                  cnt      <= '0;
                  if (idx == 3'd7) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // tbl already holds bit 7 written on the DONE-entry edge
               done     <= 1'b0;
               pass     <= (tbl == exp_q);
               mismatch <= tbl ^ exp_q;
               idx      <= '0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
